// File: rtl/cp0_exc_sequencer_if.sv
// rtl/cp0_exc_sequencer_if.sv - request, CP0 strobe and PC-redirect bundle of the exception sequencer
// Signals:
//   req_syscall, req_break, req_teq, eret_req : one-cycle request pulses from decode/execute
//   ext_irq                                   : level external interrupt
//   cpu_mtc0                                  : MTC0 executing this cycle
//   status, exc_addr                          : CP0 registers 12 and 14
//   exception, cause, must_exception, eret    : strobes towards CP0
//   pc_load, pc_target                        : PC mux select and redirect address
//   stall, depth, drop, overflow              : pipeline freeze and sequencer status
// master: the sequencer; slave: the surrounding CPU/CP0 side.
interface cp0_exc_sequencer_if;
   logic        req_syscall;
   logic        req_break;
   logic        req_teq;
   logic        ext_irq;
   logic        eret_req;
   logic        cpu_mtc0;
   logic [31:0] status;
   logic [31:0] exc_addr;
   logic        exception;
   logic [4:0]  cause;
   logic        must_exception;
   logic        eret;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        stall;
   logic [2:0]  depth;
   logic        drop;
   logic        overflow;

   modport master (
      input  req_syscall, req_break, req_teq, ext_irq, eret_req, cpu_mtc0, status, exc_addr,
      output exception, cause, must_exception, eret, pc_load, pc_target, stall, depth, drop, overflow
   );

   modport slave (
      output req_syscall, req_break, req_teq, ext_irq, eret_req, cpu_mtc0, status, exc_addr,
      input  exception, cause, must_exception, eret, pc_load, pc_target, stall, depth, drop, overflow
   );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// rtl/cp0_exc_sequencer.sv - latches, prioritises and sequences exception entry and ERET exit around CP0
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cp0_exc_sequencer_if.master (requests/CP0 registers in; CP0 strobes, PC redirect, status out)
// Parameters:
//   HANDLER_ADDR : PC loaded on exception entry
//   MAX_DEPTH    : deepest allowed nesting before entries are refused
module cp0_exc_sequencer #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
   parameter int          MAX_DEPTH    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   cp0_exc_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_VECT,
      ST_RET,
      ST_RETPC
   } state_t;

   typedef enum logic [1:0] {
      SRC_IRQ,
      SRC_TEQ,
      SRC_BRK,
      SRC_SYS
   } src_t;

   localparam logic [4:0] CAUSE_IRQ = 5'b00000;
   localparam logic [4:0] CAUSE_TEQ = 5'b01101;
   localparam logic [4:0] CAUSE_BRK = 5'b01001;
   localparam logic [4:0] CAUSE_SYS = 5'b01000;
   localparam logic [2:0] DEPTH_MAX = 3'(MAX_DEPTH);

   state_t      state;
   logic        pend_sys;
   logic        pend_brk;
   logic        pend_teq;
   logic        pend_irq;
   logic        pend_eret;

   logic        win_valid;
   logic        win_en;
   src_t        win_src;
   logic [4:0]  win_cause;

   // A masked irq is never a candidate: it cannot be dropped (it is a level)
   // and must not hide lower-priority synchronous requests behind it.
   always_comb begin
      win_valid = 1'b0;
      win_en    = 1'b0;
      win_src   = SRC_SYS;
      win_cause = CAUSE_SYS;
      if (pend_irq && bus.status[0] && bus.status[4]) begin
         win_valid = 1'b1;
         win_en    = 1'b1;
         win_src   = SRC_IRQ;
         win_cause = CAUSE_IRQ;
      end else if (pend_teq) begin
         win_valid = 1'b1;
         win_en    = bus.status[0] & bus.status[3];
         win_src   = SRC_TEQ;
         win_cause = CAUSE_TEQ;
      end else if (pend_brk) begin
         win_valid = 1'b1;
         win_en    = bus.status[0] & bus.status[2];
         win_src   = SRC_BRK;
         win_cause = CAUSE_BRK;
      end else if (pend_sys) begin
         win_valid = 1'b1;
         win_en    = bus.status[0] & bus.status[1];
         win_src   = SRC_SYS;
         win_cause = CAUSE_SYS;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= ST_IDLE;
         pend_sys           <= 1'b0;
         pend_brk           <= 1'b0;
         pend_teq           <= 1'b0;
         pend_irq           <= 1'b0;
         pend_eret          <= 1'b0;
         bus.exception      <= 1'b0;
         bus.cause          <= 5'd0;
         bus.must_exception <= 1'b0;
         bus.eret           <= 1'b0;
         bus.pc_load        <= 1'b0;
         bus.pc_target      <= 32'd0;
         bus.stall          <= 1'b0;
         bus.depth          <= 3'd0;
         bus.drop           <= 1'b0;
         bus.overflow       <= 1'b0;
      end else begin
         // Collect new pulses; a clear issued later in this block wins, so a
         // pulse coinciding with arbitration of the same source is merged.
         pend_irq  <= bus.ext_irq;
         pend_sys  <= pend_sys  | bus.req_syscall;
         pend_brk  <= pend_brk  | bus.req_break;
         pend_teq  <= pend_teq  | bus.req_teq;
         pend_eret <= pend_eret | bus.eret_req;
         bus.drop  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  case (win_src)
                     SRC_TEQ: pend_teq <= 1'b0;
                     SRC_BRK: pend_brk <= 1'b0;
                     SRC_SYS: pend_sys <= 1'b0;
                     default: ;
                  endcase
                  if (!win_en) begin
                     bus.drop <= 1'b1;
                  end else if (bus.depth == DEPTH_MAX) begin
                     bus.overflow <= 1'b1;
                     bus.drop     <= 1'b1;
                  end else begin
                     state              <= ST_SAVE;
                     bus.cause          <= win_cause;
                     bus.exception      <= 1'b1;
                     bus.must_exception <= 1'b1;
                     bus.stall          <= 1'b1;
                  end
               end else if (pend_eret) begin
                  if (bus.depth != 3'd0) begin
                     state     <= ST_RET;
                     bus.eret  <= 1'b1;
                     bus.stall <= 1'b1;
                  end else begin
                     pend_eret <= 1'b0;
                     bus.drop  <= 1'b1;
                  end
               end
            end
            // CP0 lets an MTC0 win the write port, so entry is only committed
            // on an edge where no MTC0 is executing.
            ST_SAVE: begin
               if (!bus.cpu_mtc0) begin
                  state              <= ST_VECT;
                  bus.exception      <= 1'b0;
                  bus.must_exception <= 1'b0;
                  bus.pc_load        <= 1'b1;
                  bus.pc_target      <= HANDLER_ADDR;
                  bus.depth          <= bus.depth + 3'd1;
               end
            end
            ST_VECT: begin
               state         <= ST_IDLE;
               bus.pc_load   <= 1'b0;
               bus.pc_target <= 32'd0;
               bus.stall     <= 1'b0;
            end
            ST_RET: begin
               if (!bus.cpu_mtc0) begin
                  state         <= ST_RETPC;
                  bus.eret      <= 1'b0;
                  bus.pc_load   <= 1'b1;
                  bus.pc_target <= bus.exc_addr + 32'd4;
                  bus.depth     <= bus.depth - 3'd1;
                  pend_eret     <= 1'b0;
               end
            end
            ST_RETPC: begin
               state         <= ST_IDLE;
               bus.pc_load   <= 1'b0;
               bus.pc_target <= 32'd0;
               bus.stall     <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb/tb_cp0_exc_sequencer.sv - directed scoreboard bench for cp0_exc_sequencer
module tb_cp0_exc_sequencer;
   logic clk;
   logic rst;

   cp0_exc_sequencer_if bus ();

   cp0_exc_sequencer #(
      .HANDLER_ADDR (32'h0000_0004),
      .MAX_DEPTH    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] target;
      logic [2:0]  depth;
   } pc_exp_t;

   pc_exp_t    pc_q[$];
   logic [4:0] cause_q[$];

   int   total = 0;
   int   bad   = 0;
   int   drop_cnt = 0;
   int   must_rise = 0;
   int   must_hi = 0;
   logic prev_must = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled on the falling edge, scoreboard popped on events.
   task automatic step();
      pc_exp_t e;
      logic [4:0] c;
      @(posedge clk);
      @(negedge clk);
      if (bus.drop === 1'b1) drop_cnt++;
      if (bus.must_exception === 1'b1) must_hi++;
      if (bus.must_exception === 1'b1 && !prev_must) begin
         must_rise++;
         total++;
         assert (cause_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_entry observed=cause %0h expected=no entry", bus.cause);
         end
         if (cause_q.size() != 0) begin
            c = cause_q.pop_front();
            chk("entry_cause", bus.cause, c);
            chk("entry_exception", bus.exception, 1'b1);
            chk("entry_stall", bus.stall, 1'b1);
         end
      end
      prev_must = (rst === 1'b1) ? 1'b0 : bus.must_exception;
      if (bus.pc_load === 1'b1) begin
         total++;
         assert (pc_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_pc_load observed=target %0h expected=no load", bus.pc_target);
         end
         if (pc_q.size() != 0) begin
            e = pc_q.pop_front();
            chk("pc_target", bus.pc_target, e.target);
            chk("pc_depth", bus.depth, e.depth);
            chk("pc_stall", bus.stall, 1'b1);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_exception"}, bus.exception, 1'b0);
      chk({tag, "_cause"}, bus.cause, 5'd0);
      chk({tag, "_must"}, bus.must_exception, 1'b0);
      chk({tag, "_eret"}, bus.eret, 1'b0);
      chk({tag, "_pc_load"}, bus.pc_load, 1'b0);
      chk({tag, "_pc_target"}, bus.pc_target, 32'd0);
      chk({tag, "_stall"}, bus.stall, 1'b0);
      chk({tag, "_depth"}, bus.depth, 3'd0);
      chk({tag, "_drop"}, bus.drop, 1'b0);
      chk({tag, "_overflow"}, bus.overflow, 1'b0);
   endtask

   initial begin
      int d0;
      int m0;
      rst             = 1'b1;
      bus.req_syscall = 1'b0;
      bus.req_break   = 1'b0;
      bus.req_teq     = 1'b0;
      bus.ext_irq     = 1'b0;
      bus.eret_req    = 1'b0;
      bus.cpu_mtc0    = 1'b0;
      bus.status      = 32'h1F;
      bus.exc_addr    = 32'h0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // syscall: entry two cycles after the pulse, redirect after three
      cause_q.push_back(5'b01000);
      pc_q.push_back('{32'h4, 3'd1});
      bus.req_syscall = 1'b1;
      step();
      bus.req_syscall = 1'b0;
      chk("sys_t1_must", bus.must_exception, 1'b0);
      step();
      chk("sys_t2_must", bus.must_exception, 1'b1);
      chk("sys_t2_cause", bus.cause, 5'b01000);
      step();
      chk("sys_t3_pc_load", bus.pc_load, 1'b1);
      chk("sys_t3_depth", bus.depth, 3'd1);
      step();
      chk("sys_idle_stall", bus.stall, 1'b0);

      // ERET at depth 1
      bus.exc_addr = 32'h100;
      pc_q.push_back('{32'h104, 3'd0});
      bus.eret_req = 1'b1;
      step();
      bus.eret_req = 1'b0;
      step();
      chk("eret_t2_eret", bus.eret, 1'b1);
      chk("eret_t2_stall", bus.stall, 1'b1);
      step();
      chk("eret_t3_eret", bus.eret, 1'b0);
      chk("eret_t3_pc_load", bus.pc_load, 1'b1);
      step();
      chk("eret_done_depth", bus.depth, 3'd0);

      // ERET at depth 0 is only dropped
      d0 = drop_cnt;
      bus.eret_req = 1'b1;
      step();
      bus.eret_req = 1'b0;
      step();
      chk("eret0_drop", bus.drop, 1'b1);
      chk("eret0_eret", bus.eret, 1'b0);
      step();
      chk("eret0_drop_pulse", bus.drop, 1'b0);
      step();
      chk("eret0_drop_cnt", drop_cnt - d0, 1);

      // teq and break together: teq first, break right after
      cause_q.push_back(5'b01101);
      cause_q.push_back(5'b01001);
      pc_q.push_back('{32'h4, 3'd1});
      pc_q.push_back('{32'h4, 3'd2});
      bus.req_teq   = 1'b1;
      bus.req_break = 1'b1;
      step();
      bus.req_teq   = 1'b0;
      bus.req_break = 1'b0;
      step();
      chk("teq_first_cause", bus.cause, 5'b01101);
      for (int i = 0; i < 6; i++) step();
      chk("teqbrk_depth", bus.depth, 3'd2);
      chk("teqbrk_pc_q_empty", pc_q.size(), 0);

      // syscall disabled: one drop, no entry, not left pending
      bus.status = 32'h1;
      d0 = drop_cnt;
      m0 = must_rise;
      bus.req_syscall = 1'b1;
      step();
      bus.req_syscall = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("dis_drop_cnt", drop_cnt - d0, 1);
      bus.status = 32'h1F;
      for (int i = 0; i < 4; i++) step();
      chk("dis_no_entry", must_rise - m0, 0);

      // masked irq is neither taken nor dropped
      bus.status  = 32'h0F;
      bus.ext_irq = 1'b1;
      d0 = drop_cnt;
      for (int i = 0; i < 4; i++) step();
      bus.ext_irq = 1'b0;
      step();
      bus.status = 32'h1F;
      step();
      chk("irq_masked_drop", drop_cnt - d0, 0);
      chk("irq_masked_entry", must_rise - m0, 0);

      // MTC0 holds SAVE for three cycles
      cause_q.push_back(5'b01000);
      pc_q.push_back('{32'h4, 3'd3});
      must_hi = 0;
      bus.req_syscall = 1'b1;
      step();
      bus.req_syscall = 1'b0;
      step();
      chk("mtc0_t2_must", bus.must_exception, 1'b1);
      bus.cpu_mtc0 = 1'b1;
      step();
      chk("mtc0_t3_pc_load", bus.pc_load, 1'b0);
      step();
      step();
      chk("mtc0_t5_must", bus.must_exception, 1'b1);
      bus.cpu_mtc0 = 1'b0;
      step();
      chk("mtc0_t6_pc_load", bus.pc_load, 1'b1);
      chk("mtc0_t6_must", bus.must_exception, 1'b0);
      chk("mtc0_must_cycles", must_hi, 4);
      step();

      // entry refused at MAX_DEPTH
      bus.req_syscall = 1'b1;
      step();
      bus.req_syscall = 1'b0;
      step();
      chk("ovf_drop", bus.drop, 1'b1);
      chk("ovf_flag", bus.overflow, 1'b1);
      chk("ovf_must", bus.must_exception, 1'b0);
      step();
      chk("ovf_drop_pulse", bus.drop, 1'b0);
      chk("ovf_sticky", bus.overflow, 1'b1);
      chk("ovf_depth", bus.depth, 3'd3);

      // return one level (wrap-free target), overflow stays set
      bus.exc_addr = 32'h200;
      pc_q.push_back('{32'h204, 3'd2});
      bus.eret_req = 1'b1;
      step();
      bus.eret_req = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("ret2_depth", bus.depth, 3'd2);
      chk("ret2_overflow", bus.overflow, 1'b1);

      // reset asserted while in VECT clears everything at once
      cause_q.push_back(5'b01000);
      pc_q.push_back('{32'h4, 3'd3});
      bus.req_syscall = 1'b1;
      step();
      bus.req_syscall = 1'b0;
      step();
      step();
      chk("vect_pc_load", bus.pc_load, 1'b1);
      #1 rst = 1'b1;
      #1 chk_all_zero("midrst");
      step();
      rst = 1'b0;
      m0 = must_rise;
      for (int i = 0; i < 4; i++) step();
      chk("postrst_no_entry", must_rise - m0, 0);
      chk("postrst_stall", bus.stall, 1'b0);
      chk("cause_q_left", cause_q.size(), 0);
      chk("pc_q_left", pc_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
